// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer and bit-centre sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit after data bit 7 and the rx_parity_err strobe.
module uart_rx #(
  parameter int CLK_DIV = 5208,
  parameter int CNT_W   = 13
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd5,
`endif
    WAIT_HIGH = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_DIV - 1);

  // High when data bits plus the received parity bit do not XOR to zero.
  function automatic logic parity_bad(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic [1:0]       sync_r;
  logic             rx_s;
  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       bit_idx_r, bit_idx_nxt_s;
  logic [7:0]       shift_r, shift_nxt_s;
  logic             tick_s, half_tick_s;
  logic             valid_nxt_s, ferr_nxt_s;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_r, par_bit_nxt_s;
`endif

  assign rx_s        = sync_r[1];
  assign tick_s      = (cnt_r == FULL_LAST);
  assign half_tick_s = (cnt_r == HALF_LAST);

  // State register, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_r        <= 2'b11;
      state_r       <= IDLE;
      cnt_r         <= '0;
      bit_idx_r     <= 3'd0;
      shift_r       <= 8'h00;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r     <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      sync_r        <= {sync_r[0], rx};
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      bit_idx_r     <= bit_idx_nxt_s;
      shift_r       <= shift_nxt_s;
      rx_valid      <= valid_nxt_s;
      rx_frame_err  <= ferr_nxt_s;
      rx_busy       <= (state_nxt_s != IDLE);
      rx_data       <= valid_nxt_s ? shift_r : rx_data;
`ifdef UART_RX_PARITY_EN
      par_bit_r     <= par_bit_nxt_s;
      rx_parity_err <= valid_nxt_s & parity_bad(shift_r, par_bit_r);
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!rx_s) state_nxt_s = START;
        else       state_nxt_s = IDLE;
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (half_tick_s) state_nxt_s = rx_s ? IDLE : DATA;
        else             state_nxt_s = START;
      end
      DATA: begin
`ifdef UART_RX_PARITY_EN
        if (tick_s && bit_idx_r == 3'd7) state_nxt_s = PARITY;
`else
        if (tick_s && bit_idx_r == 3'd7) state_nxt_s = STOP;
`endif
        else                             state_nxt_s = DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_s) state_nxt_s = STOP;
        else        state_nxt_s = PARITY;
      end
`endif
      STOP: begin
        if (tick_s) state_nxt_s = rx_s ? IDLE : WAIT_HIGH;
        else        state_nxt_s = STOP;
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt_s = IDLE;
        else      state_nxt_s = WAIT_HIGH;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Counter, bit index, shift register and strobe decode.
  always_comb begin
    cnt_nxt_s     = cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    valid_nxt_s   = 1'b0;
    ferr_nxt_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_nxt_s = par_bit_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_nxt_s = '0;
      end
      START: begin
        if (half_tick_s) begin
          cnt_nxt_s     = '0;
          bit_idx_nxt_s = 3'd0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (tick_s) begin
          cnt_nxt_s            = '0;
          shift_nxt_s[bit_idx_r] = rx_s;
          bit_idx_nxt_s        = (bit_idx_r == 3'd7) ? bit_idx_r : bit_idx_r + 3'd1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_s) begin
          cnt_nxt_s     = '0;
          par_bit_nxt_s = rx_s;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (tick_s) begin
          cnt_nxt_s   = '0;
          valid_nxt_s = rx_s;
          ferr_nxt_s  = ~rx_s;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        cnt_nxt_s = '0;
      end
      default: begin
        cnt_nxt_s = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random bytes against a frame-level model.
// Two instances: CLK_DIV=16 for most scenarios, CLK_DIV=17 for the zero-gap stream.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int DIV_A = 16;
  localparam int DIV_B = 17;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst, rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;
`ifdef UART_RX_PARITY_EN
  logic       perr_a, perr_b;
`endif

  uart_rx #(.CLK_DIV(DIV_A), .CNT_W(5)) dut_a (
    .clk(clk), .srst(srst), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_frame_err(ferr_a),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(perr_a),
`endif
    .rx_busy(busy_a));

  uart_rx #(.CLK_DIV(DIV_B), .CNT_W(5)) dut_b (
    .clk(clk), .srst(srst), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_frame_err(ferr_b),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(perr_b),
`endif
    .rx_busy(busy_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid_a = 0, n_valid_b = 0, n_ferr_a = 0, n_ferr_b = 0;
  int n_overlap = 0, n_perr_a = 0, n_perr_alone = 0;
  int last_valid_cyc_a = 0;
  logic [7:0] got_a[$], got_b[$], exp_a[$], exp_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (valid_a) begin
      n_valid_a <= n_valid_a + 1;
      got_a.push_back(data_a);
      last_valid_cyc_a <= cyc;
    end
    if (valid_b) begin
      n_valid_b <= n_valid_b + 1;
      got_b.push_back(data_b);
    end
    if (ferr_a) n_ferr_a <= n_ferr_a + 1;
    if (ferr_b) n_ferr_b <= n_ferr_b + 1;
    if ((valid_a && ferr_a) || (valid_b && ferr_b)) n_overlap <= n_overlap + 1;
`ifdef UART_RX_PARITY_EN
    if (perr_a) n_perr_a <= n_perr_a + 1;
    if ((perr_a && !valid_a) || (perr_b && !valid_b)) n_perr_alone <= n_perr_alone + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serialises one frame: start, 8 data bits LSB first, optional even parity, stop.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop_bit,
                            input logic par_flip);
    int div;
    logic pbit;
    div  = sel ? DIV_B : DIV_A;
    pbit = (^d) ^ par_flip;
    set_rx(sel, 1'b0);
    hold(div);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      hold(div);
    end
    if (PAR_BITS == 1) begin
      set_rx(sel, pbit);
      hold(div);
    end
    set_rx(sel, stop_bit);
    hold(div);
  endtask

  // Drains received bytes of instance A against the model queue.
  task automatic compare_a(input string tag);
    check({tag, "_count"}, got_a.size(), exp_a.size());
    while (got_a.size() > 0 && exp_a.size() > 0)
      check(tag, got_a.pop_front(), exp_a.pop_front());
    got_a.delete();
    exp_a.delete();
  endtask

  initial begin
    int c0, v0, f0, lat_exp;
    logic [7:0] b, part;

    // Reset and idle line.
    srst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    hold(3);
    srst = 1'b0;
    hold(200);
    check("rst_data", data_a, 8'h00);
    check("rst_valid", valid_a, 1'b0);
    check("rst_ferr", ferr_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_data_b", data_b, 8'h00);
    check("idle_no_strobe", n_valid_a + n_ferr_a + n_valid_b + n_ferr_b, 0);

    // Single byte with latency measured from the rx pin edge.
    c0 = cyc;
    send_frame(1'b0, 8'hA5, 1'b1, 1'b0);
    exp_a.push_back(8'hA5);
    hold(4);
    lat_exp = 3 + DIV_A / 2 + (9 + PAR_BITS) * DIV_A;
    check("single_latency", last_valid_cyc_a - c0, lat_exp);
    check("single_data_hold", data_a, 8'hA5);
    check("single_ferr", n_ferr_a, 0);
    compare_a("single");

    // Glitch shorter than half a bit.
    v0 = n_valid_a; f0 = n_ferr_a;
    set_rx(1'b0, 1'b0);
    hold(4);
    check("glitch_busy_seen", busy_a, 1'b1);
    set_rx(1'b0, 1'b1);
    hold(10);
    check("glitch_busy_clear", busy_a, 1'b0);
    check("glitch_no_strobe", (n_valid_a - v0) + (n_ferr_a - f0), 0);

    // Framing error followed by a break.
    v0 = n_valid_a; f0 = n_ferr_a;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
    hold(40);
    check("ferr_once", n_ferr_a - f0, 1);
    check("ferr_no_valid", n_valid_a - v0, 0);
    check("ferr_data_kept", data_a, 8'hA5);
    check("break_busy", busy_a, 1'b1);
    set_rx(1'b0, 1'b1);
    hold(8);
    check("break_released", busy_a, 1'b0);
    check("break_no_frames", n_valid_a - v0, 0);

    // Zero-gap stream on the CLK_DIV=17 instance.
    foreach (exp_b[i]) exp_b.delete(i);
    send_frame(1'b1, 8'h00, 1'b1, 1'b0); exp_b.push_back(8'h00);
    send_frame(1'b1, 8'hFF, 1'b1, 1'b0); exp_b.push_back(8'hFF);
    send_frame(1'b1, 8'h55, 1'b1, 1'b0); exp_b.push_back(8'h55);
    hold(20);
    check("b2b_count", got_b.size(), 3);
    check("b2b_ferr", n_ferr_b, 0);
    while (got_b.size() > 0 && exp_b.size() > 0)
      check("b2b_data", got_b.pop_front(), exp_b.pop_front());

    // Reset in the middle of data bit 4 of 8'hC3.
    v0 = n_valid_a; f0 = n_ferr_a;
    part = 8'hC3;
    set_rx(1'b0, 1'b0);
    hold(DIV_A);
    for (int i = 0; i < 4; i++) begin
      set_rx(1'b0, part[i]);
      hold(DIV_A);
    end
    set_rx(1'b0, part[4]);
    hold(DIV_A / 2);
    srst = 1'b1;
    set_rx(1'b0, 1'b1);
    hold(2);
    check("midrst_busy", busy_a, 1'b0);
    srst = 1'b0;
    hold(40);
    check("midrst_no_strobe", (n_valid_a - v0) + (n_ferr_a - f0), 0);
    check("midrst_data_reset", data_a, 8'h00);
    send_frame(1'b0, 8'h81, 1'b1, 1'b0);
    exp_a.push_back(8'h81);
    hold(DIV_A);
    compare_a("after_rst");

`ifdef UART_RX_PARITY_EN
    // Wrong parity: byte still delivered, parity strobe alongside valid.
    v0 = n_perr_a;
    send_frame(1'b0, 8'h01, 1'b1, 1'b1);
    exp_a.push_back(8'h01);
    hold(DIV_A);
    check("parity_err_once", n_perr_a - v0, 1);
    compare_a("parity");
`endif

    // Random bytes with random idle gaps against the model queue.
    f0 = n_ferr_a;
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(1'b0, b, 1'b1, 1'b0);
      exp_a.push_back(b);
      hold($urandom_range(0, 12));
    end
    hold(DIV_A);
    compare_a("random");
    check("random_no_ferr", n_ferr_a - f0, 0);

    check("no_valid_ferr_overlap", n_overlap, 0);
    check("perr_only_with_valid", n_perr_alone, 0);
    check("perr_total", n_perr_a, PAR_BITS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
